result_drain_reader: RTL and testbench

Reader side of the results SRAM. The array-side writer fills that SRAM with one MATRIX_SIZE x PARTIAL_SUM_BW row per address. This block reads a programmed range of rows back out and serializes each row into LANES-wide beats on a valid/ready stream toward the host/output interface. It sits beside the results SRAM, shares its address/read port, and yields whenever the writer is active.

---
 rtl/result_drain_reader_pkg.sv | 36 +++
 rtl/result_drain_reader_row_serializer.sv | 63 ++++++
 rtl/result_drain_reader.sv | 132 +++++++++++++
 tb/tb_result_drain_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_reader_pkg.sv
// Shared definitions for the results-SRAM drain reader.
// Holds the FSM state encoding, the default geometry of the results SRAM,
// and helpers that derive the beat geometry (beats per row, beat width,
// beat index width) from the row geometry.
package result_drain_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_LAT = 3'd2,
        ST_SEND   = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam int DEF_ADDRESSSIZE    = 10;
    localparam int DEF_MATRIX_SIZE    = 32;
    localparam int DEF_PARTIAL_SUM_BW = 24;
    localparam int DEF_LANES          = 4;

    function automatic int calc_bpr(input int matrix_size, input int lanes);
        return matrix_size / lanes;
    endfunction

    function automatic int calc_beat_w(input int lanes, input int partial_sum_bw);
        return lanes * partial_sum_bw;
    endfunction

    // A single-beat row still needs a 1-bit index register.
    function automatic int calc_idx_w(input int bpr);
        return (bpr > 1) ? $clog2(bpr) : 1;
    endfunction

    localparam int DEF_BPR    = calc_bpr(DEF_MATRIX_SIZE, DEF_LANES);
    localparam int DEF_BEAT_W = calc_beat_w(DEF_LANES, DEF_PARTIAL_SUM_BW);

endpackage

// File: rtl/result_drain_reader_row_serializer.sv
// Row serializer for the drain reader.
// Captures one SRAM row into row_buf and presents it as BPR beats of BEAT_W
// bits on a valid/ready stream, lowest lanes first.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          capture sram_rdata into row_buf and restart at beat 0
//   sram_rdata    full SRAM row
//   active        stream is presenting beats of row_buf
//   m_ready       sink ready
//   m_valid       beat valid
//   m_data        current beat payload
//   m_row_last    current beat is the last beat of the row
//   row_done      last beat of the row transfers this cycle
module result_drain_reader_row_serializer
    import result_drain_reader_pkg::*;
#(
    parameter int BPR      = DEF_BPR,
    parameter int BEAT_W   = DEF_BEAT_W,
    parameter int WORDSIZE = BPR * BEAT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WORDSIZE-1:0] sram_rdata,
    input  logic                active,
    input  logic                m_ready,
    output logic                m_valid,
    output logic [BEAT_W-1:0]   m_data,
    output logic                m_row_last,
    output logic                row_done
);

    localparam int IDX_W = calc_idx_w(BPR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPR - 1);

    // Row viewed as an array of beats; element 0 holds the lowest lanes.
    logic [BPR-1:0][BEAT_W-1:0] row_buf;
    logic [IDX_W-1:0]           beat_idx;
    logic                       fire;
    logic                       at_last;

    assign at_last    = (beat_idx == LAST_IDX);
    assign fire       = active && m_ready;
    assign m_valid    = active;
    assign m_data     = row_buf[beat_idx];
    assign m_row_last = active && at_last;
    assign row_done   = fire && at_last;

    // Payload and index only move on load or on a handshake, so a stalled
    // beat stays stable until the sink takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_buf  <= '0;
            beat_idx <= '0;
        end else if (load) begin
            row_buf  <= sram_rdata;
            beat_idx <= '0;
        end else if (fire) begin
            beat_idx <= at_last ? '0 : beat_idx + 1'b1;
        end
    end

endmodule

// File: rtl/result_drain_reader.sv
// Results-SRAM drain reader.
// Reads num_rows consecutive rows starting at base_addr from the results SRAM
// (address wraps modulo 2^ADDRESSSIZE), yielding the read port whenever the
// writer owns it, and streams each row out as MATRIX_SIZE/LANES beats.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    launch pulse, accepted only when idle
//   base_addr, num_rows      drain range, sampled on an accepted start
//   busy, done               drain in progress / one-cycle completion pulse
//   sram_rd_en, sram_addr    read request toward the results SRAM
//   sram_rdata               row data, valid the cycle after sram_rd_en
//   sram_wr_busy             writer owns the SRAM; no read may issue
//   m_valid, m_ready, m_data beat stream
//   m_row_last, m_last       last beat of row / last beat of the drain
module result_drain_reader
    import result_drain_reader_pkg::*;
#(
    parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int LANES          = DEF_LANES,
    parameter int WORDSIZE       = PARTIAL_SUM_BW * MATRIX_SIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDRESSSIZE-1:0]          base_addr,
    input  logic [ADDRESSSIZE-1:0]          num_rows,
    output logic                            busy,
    output logic                            done,
    output logic                            sram_rd_en,
    output logic [ADDRESSSIZE-1:0]          sram_addr,
    input  logic [WORDSIZE-1:0]             sram_rdata,
    input  logic                            sram_wr_busy,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [LANES*PARTIAL_SUM_BW-1:0] m_data,
    output logic                            m_row_last,
    output logic                            m_last
);

    localparam int BPR    = calc_bpr(MATRIX_SIZE, LANES);
    localparam int BEAT_W = calc_beat_w(LANES, PARTIAL_SUM_BW);
    localparam logic [ADDRESSSIZE-1:0] ONE_ROW = ADDRESSSIZE'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDRESSSIZE-1:0] row_addr;
    logic [ADDRESSSIZE-1:0] rows_left;
    logic                   row_done;
    logic                   last_row;

    assign last_row  = (rows_left == ONE_ROW);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign sram_addr = row_addr;
    assign m_last    = m_row_last && last_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sram_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                // The writer has priority; wait as long as it holds the port.
                if (!sram_wr_busy) begin
                    sram_rd_en = 1'b1;
                    state_d    = ST_RD_LAT;
                end
            end
            ST_RD_LAT: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (row_done) begin
                    state_d = last_row ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Range registers are only written on an accepted start, so a start
    // arriving mid-drain cannot disturb the transfer in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_addr  <= '0;
            rows_left <= '0;
        end else if (state_q == ST_IDLE && start) begin
            row_addr  <= base_addr;
            rows_left <= num_rows;
        end else if (state_q == ST_SEND && row_done) begin
            rows_left <= rows_left - 1'b1;
            row_addr  <= row_addr + 1'b1;
        end
    end

    result_drain_reader_row_serializer #(
        .BPR      (BPR),
        .BEAT_W   (BEAT_W),
        .WORDSIZE (WORDSIZE)
    ) u_row_serializer (
        .clk        (clk),
        .rst        (rst),
        .load       (state_q == ST_RD_LAT),
        .sram_rdata (sram_rdata),
        .active     (state_q == ST_SEND),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_row_last (m_row_last),
        .row_done   (row_done)
    );

endmodule

// File: tb/tb_result_drain_reader.sv
module tb_result_drain_reader;

    localparam int AW    = 10;
    localparam int MS    = 32;
    localparam int PSBW  = 24;
    localparam int LANES = 4;
    localparam int BPR   = MS / LANES;
    localparam int BW    = LANES * PSBW;
    localparam int WS    = MS * PSBW;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          row_last;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic          busy;
    logic          done;
    logic          sram_rd_en;
    logic [AW-1:0] sram_addr;
    logic [WS-1:0] sram_rdata;
    logic          sram_wr_busy;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_data;
    logic          m_row_last;
    logic          m_last;

    result_drain_reader #(
        .ADDRESSSIZE    (AW),
        .MATRIX_SIZE    (MS),
        .PARTIAL_SUM_BW (PSBW),
        .LANES          (LANES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .busy         (busy),
        .done         (done),
        .sram_rd_en   (sram_rd_en),
        .sram_addr    (sram_addr),
        .sram_rdata   (sram_rdata),
        .sram_wr_busy (sram_wr_busy),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_row_last   (m_row_last),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    // Reference contents: partial sum k of row a.
    logic [PSBW-1:0] psum [0:DEPTH-1][0:MS-1];

    beat_t exp_q[$];
    int    exp_addr_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int beats_seen = 0;
    int done_cnt   = 0;
    int rdy_mode   = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int wr_mode    = 0;   // 0: writer idle (unless a test drives it), 1: random

    task automatic check(input bit ok, input string name,
                         input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Synchronous-read SRAM model: data appears the cycle after the request.
    always @(posedge clk) begin
        if (sram_rd_en) begin
            for (int k = 0; k < MS; k++) sram_rdata[k*PSBW +: PSBW] <= psum[sram_addr][k];
        end
    end

    // Sink ready generator.
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    m_ready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                2:       m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Random writer activity.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_mode == 1) sram_wr_busy = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor / scoreboard.
    logic          stall_prev = 1'b0;
    logic [BW-1:0] prev_data;
    logic          prev_row_last;
    logic          prev_last;

    always @(negedge clk) begin
        beat_t e;
        int    ea;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (sram_rd_en) begin
                check(!sram_wr_busy, "read_during_writer", BW'(sram_wr_busy), '0);
                if (exp_addr_q.size() == 0) begin
                    check(1'b0, "unexpected_read", BW'(sram_addr), '0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check(sram_addr == AW'(ea), "sram_addr", BW'(sram_addr), BW'(ea));
                end
            end
            if (stall_prev) begin
                check(m_valid, "valid_held", BW'(m_valid), BW'(1));
                check(m_data == prev_data && m_row_last == prev_row_last && m_last == prev_last,
                      "beat_held", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", m_data, '0);
                end else begin
                    e = exp_q.pop_front();
                    check(m_data == e.data, "beat_data", m_data, e.data);
                    check(m_row_last == e.row_last && m_last == e.last, "beat_flags",
                          BW'({m_row_last, m_last}), BW'({e.row_last, e.last}));
                end
            end
            if (done) done_cnt++;
            stall_prev    = m_valid && !m_ready;
            prev_data     = m_data;
            prev_row_last = m_row_last;
            prev_last     = m_last;
        end
    end

    task automatic push_expected(input int base, input int n);
        beat_t e;
        int    a;
        for (int r = 0; r < n; r++) begin
            a = (base + r) % DEPTH;
            exp_addr_q.push_back(a);
            for (int b = 0; b < BPR; b++) begin
                for (int l = 0; l < LANES; l++) e.data[l*PSBW +: PSBW] = psum[a][b*LANES + l];
                e.row_last = (b == BPR - 1);
                e.last     = e.row_last && (r == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int base, input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        num_rows  = AW'(n);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_rows  = AW'($urandom);
    endtask

    task automatic drain(input int base, input int n, input bit contend, input bit mid);
        int first_rd, first_val, first_done, beats0, done0;
        push_expected(base, n);
        beats0 = beats_seen;
        done0  = done_cnt;
        pulse_start(base, n);
        if (contend) begin
            sram_wr_busy = 1'b1;
            fork
                begin
                    repeat (5) @(posedge clk);
                    #1 sram_wr_busy = 1'b0;
                end
            join_none
        end
        first_rd = -1; first_val = -1; first_done = -1;
        for (int k = 1; k <= 4000 && first_done < 0; k++) begin
            @(negedge clk);
            if (k == 1) check(busy, "busy_after_start", BW'(busy), BW'(1));
            if (sram_rd_en && first_rd < 0) first_rd = k;
            if (m_valid && first_val < 0) first_val = k;
            if (done) first_done = k;
            if (mid && first_val > 0 && k == first_val + 2) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                num_rows  = AW'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check(first_done > 0, "done_timeout", BW'(first_done), BW'(1));
        if (n == 0) begin
            check(first_done == 1, "zero_rows_done_latency", BW'(first_done), BW'(1));
            check(first_rd < 0 && first_val < 0, "zero_rows_no_activity",
                  BW'({first_rd < 0, first_val < 0}), BW'(2'b11));
        end else if (contend) begin
            check(first_rd == 6, "contention_read_cycle", BW'(first_rd), BW'(6));
            check(first_val == 8, "contention_valid_cycle", BW'(first_val), BW'(8));
        end else if (wr_mode == 0) begin
            check(first_rd == 1, "read_latency", BW'(first_rd), BW'(1));
            check(first_val == 3, "valid_latency", BW'(first_val), BW'(3));
        end
        @(negedge clk);
        check(!busy && !done, "idle_after_done", BW'({busy, done}), '0);
        repeat (2) @(negedge clk);
        check(done_cnt - done0 == 1, "done_once", BW'(done_cnt - done0), BW'(1));
        check(beats_seen - beats0 == n * BPR, "beat_count", BW'(beats_seen - beats0), BW'(n * BPR));
        check(exp_q.size() == 0 && exp_addr_q.size() == 0, "queues_drained",
              BW'(exp_q.size() + exp_addr_q.size()), '0);
    endtask

    task automatic reset_mid_drain(input int base);
        int  beats0, done0;
        bit  hit;
        push_expected(base, 3);
        beats0 = beats_seen;
        pulse_start(base, 3);
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            #1;
            // Twelve beats counted with ready high means beat 3 of row 1 is on the bus.
            if (m_valid && beats_seen - beats0 == BPR + 4) hit = 1'b1;
        end
        check(hit, "reach_row1_beat3", BW'(hit), BW'(1));
        rst = 1'b1;
        #1;
        check({busy, done, sram_rd_en, m_valid, m_row_last, m_last} == '0, "async_reset_ctrl",
              BW'({busy, done, sram_rd_en, m_valid, m_row_last, m_last}), '0);
        check(sram_addr == '0 && m_data == '0, "async_reset_data", m_data | BW'(sram_addr), '0);
        exp_q.delete();
        exp_addr_q.delete();
        done0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check(done_cnt == done0, "no_done_after_reset", BW'(done_cnt - done0), '0);
        check(!busy && !m_valid, "idle_after_reset", BW'({busy, m_valid}), '0);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < MS; k++) psum[a][k] = PSBW'($urandom);
        for (int k = 0; k < MS; k++) psum[0][k] = PSBW'(k);

        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_rows     = '0;
        sram_wr_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({busy, done, sram_rd_en, m_valid, m_row_last, m_last} == '0, "reset_ctrl",
              BW'({busy, done, sram_rd_en, m_valid, m_row_last, m_last}), '0);
        check(sram_addr == '0 && m_data == '0, "reset_data", m_data | BW'(sram_addr), '0);
        rst = 1'b0;

        // Single row of ascending sums, full throughput.
        rdy_mode = 0;
        drain(0, 1, 1'b0, 1'b0);
        // Back-pressure with the 1,0,0,1 ready pattern.
        rdy_mode = 1;
        drain(int'($urandom_range(0, DEPTH - 1)), 2, 1'b0, 1'b0);
        // Address wrap.
        rdy_mode = 0;
        drain(1022, 3, 1'b0, 1'b0);
        // Writer holds the port for five cycles from the first read request.
        drain(int'($urandom_range(0, DEPTH - 1)), 2, 1'b1, 1'b0);
        // Empty drain.
        drain(int'($urandom_range(0, DEPTH - 1)), 0, 1'b0, 1'b0);
        // Start pulse while busy.
        rdy_mode = 2;
        drain(int'($urandom_range(0, DEPTH - 1)), 3, 1'b0, 1'b1);
        // Randomized drains with random writer activity and back-pressure.
        wr_mode = 1;
        for (int i = 0; i < 6; i++)
            drain(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
        wr_mode = 0;
        @(posedge clk);
        #2 sram_wr_busy = 1'b0;
        // Reset during beat 3 of row 1, then a fresh drain from a new base.
        rdy_mode = 0;
        reset_mid_drain(int'($urandom_range(0, DEPTH - 1)));
        drain(int'($urandom_range(0, DEPTH - 1)), 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
